// File: rtl/ip_checksum_ttl_pkg.sv
// Shared definitions for the IPv4 header checksum / TTL checker.
// Optional feature macro: IP_CKSUM_INCR_EN (stores the incrementally
// updated checksum alongside each result).
package ip_checksum_ttl_pkg;

   typedef enum logic [2:0] {
      WAIT_W1 = 3'd0,
      ACC_W2  = 3'd1,
      ACC_W3  = 3'd2,
      ACC_W4  = 3'd3,
      FOLD1   = 3'd4,
      FOLD2   = 3'd5
   } state_t;

   localparam logic [15:0] ETHERTYPE_IP = 16'h0800;
   localparam logic [7:0]  IP_VER_IHL   = 8'h45;

   // 10 halfwords of at most 0xFFFF sum to < 2^20
   localparam int ACC_W   = 20;
   localparam int TTL_W   = 8;
   localparam int CKSUM_W = 16;

   typedef struct packed {
      logic               is_good;
      logic               is_ipv4;
      logic               ttl_good;
      logic [TTL_W-1:0]   new_ttl;
`ifdef IP_CKSUM_INCR_EN
      logic [CKSUM_W-1:0] new_checksum;
`endif
   } result_t;

   localparam int RESULT_W = $bits(result_t);

   // one's-complement add; a single end-around carry is always enough
   function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction

endpackage

// File: rtl/ip_checksum_ttl_small_fifo.sv
// Two-entry result FIFO. Head entry drives dout; a push into a full FIFO
// without a same-cycle pop is dropped and flagged for one cycle.
module small_fifo #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             not_empty,
   output logic             overflow
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             full;
   logic             pop_ok;
   logic             push_ok;

   assign full      = (count == 2'd2);
   assign not_empty = (count != 2'd0);
   assign pop_ok    = pop && not_empty;
   // a pop frees the slot the new entry is written into
   assign push_ok   = push && (!full || pop_ok);
   assign dout      = mem[rd_ptr];

   // storage, pointers, occupancy and drop pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem[0]   <= '0;
         mem[1]   <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= 2'd0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_ok)
            rd_ptr <= ~rd_ptr;
         count    <= count + {1'b0, push_ok} - {1'b0, pop_ok};
         overflow <= push && !push_ok;
      end
   end

endmodule

// File: rtl/ip_checksum_ttl.sv
// IPv4 header checksum verify and TTL decrement. Accumulates the 10 header
// halfwords across four strobed words, folds the sum in two cycles and
// queues one result per header in a 2-entry FIFO.
// Optional feature macro: IP_CKSUM_INCR_EN (new checksum after TTL-1).
module ip_checksum_ttl
   import ip_checksum_ttl_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH/8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_wr,
   input  logic                  word_ETH_IP_VER,
   input  logic                  word_IP_LEN_ID,
   input  logic                  word_IP_CHECKSUM_SRC_HI,
   input  logic                  word_IP_DST_LO,
   output logic                  ip_checksum_vld,
   input  logic                  rd_check,
   output logic                  ip_checksum_is_good,
   output logic                  ip_hdr_is_ipv4,
   output logic                  ip_ttl_is_good,
   output logic [7:0]            ip_new_ttl,
   output logic [15:0]           ip_new_checksum,
   output logic                  result_overflow
);

   state_t             state;
   logic [ACC_W-1:0]   acc;
   logic [15:0]        eth_type;
   logic [7:0]         ver_ihl;
   logic [TTL_W-1:0]   ttl;
`ifdef IP_CKSUM_INCR_EN
   logic [CKSUM_W-1:0] orig_cksum;
`endif
   result_t            res;
   result_t            head;
   logic               push;
   logic [15:0]        sum16;
   logic               unused_ctrl;

   // control width is carried for bus compatibility only
   assign unused_ctrl = ^CTRL_WIDTH;

   function automatic logic [ACC_W-1:0] sum4(input logic [63:0] d);
      return {4'd0, d[63:48]} + {4'd0, d[47:32]} + {4'd0, d[31:16]} + {4'd0, d[15:0]};
   endfunction

   // header walk: first-word strobe restarts from any state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= WAIT_W1;
         acc        <= '0;
         eth_type   <= '0;
         ver_ihl    <= '0;
         ttl        <= '0;
`ifdef IP_CKSUM_INCR_EN
         orig_cksum <= '0;
`endif
      end else if (in_wr && word_ETH_IP_VER) begin
         acc      <= {4'd0, in_data[15:0]};
         eth_type <= in_data[31:16];
         ver_ihl  <= in_data[15:8];
         state    <= ACC_W2;
      end else begin
         case (state)
            ACC_W2: if (in_wr && word_IP_LEN_ID) begin
               acc   <= acc + sum4(in_data[63:0]);
               ttl   <= in_data[15:8];
               state <= ACC_W3;
            end
            ACC_W3: if (in_wr && word_IP_CHECKSUM_SRC_HI) begin
               acc        <= acc + sum4(in_data[63:0]);
`ifdef IP_CKSUM_INCR_EN
               orig_cksum <= in_data[63:48];
`endif
               state      <= ACC_W4;
            end
            ACC_W4: if (in_wr && word_IP_DST_LO) begin
               acc   <= acc + {4'd0, in_data[63:48]};
               state <= FOLD1;
            end
            FOLD1: begin
               acc   <= {3'd0, {1'b0, acc[15:0]} + {13'd0, acc[19:16]}};
               state <= FOLD2;
            end
            FOLD2:   state <= WAIT_W1;
            default: state <= WAIT_W1;
         endcase
      end
   end

   // second fold and result formation; pushed during FOLD2
   always_comb begin
      res          = '0;
      sum16        = acc[15:0] + {15'd0, acc[16]};
      res.is_good  = (sum16 == 16'hFFFF);
      res.is_ipv4  = (eth_type == ETHERTYPE_IP) && (ver_ihl == IP_VER_IHL);
      res.ttl_good = (ttl > 8'd1);
      res.new_ttl  = (ttl == 8'd0) ? 8'd0 : ttl - 8'd1;
`ifdef IP_CKSUM_INCR_EN
      res.new_checksum = ones_add(orig_cksum, 16'h0100);
`endif
   end

   assign push = (state == FOLD2);

   small_fifo #(.WIDTH(RESULT_W)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .din       (res),
      .pop       (rd_check),
      .dout      (head),
      .not_empty (ip_checksum_vld),
      .overflow  (result_overflow)
   );

   // outputs read as zero whenever no result is queued
   assign ip_checksum_is_good = ip_checksum_vld & head.is_good;
   assign ip_hdr_is_ipv4      = ip_checksum_vld & head.is_ipv4;
   assign ip_ttl_is_good      = ip_checksum_vld & head.ttl_good;
   assign ip_new_ttl          = ip_checksum_vld ? head.new_ttl : 8'd0;
`ifdef IP_CKSUM_INCR_EN
   assign ip_new_checksum     = ip_checksum_vld ? head.new_checksum : 16'd0;
`else
   assign ip_new_checksum     = 16'd0;
`endif

endmodule

// File: tb/tb_ip_checksum_ttl.sv
// Bench for ip_checksum_ttl: table vectors, hand sequences for FIFO
// overflow / reset / stalls, and random headers against a reference model.
module tb_ip_checksum_ttl;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] in_data;
   logic        in_wr;
   logic        s_w1, s_w2, s_w3, s_w4;
   logic        rd_check;
   logic        ip_checksum_vld;
   logic        ip_checksum_is_good;
   logic        ip_hdr_is_ipv4;
   logic        ip_ttl_is_good;
   logic [7:0]  ip_new_ttl;
   logic [15:0] ip_new_checksum;
   logic        result_overflow;

   int n_chk  = 0;
   int n_fail = 0;
   int ovf_cnt = 0;

   typedef struct packed {
      logic        good;
      logic        ipv4;
      logic        ttl_good;
      logic [7:0]  ttl;
      logic [15:0] ck;
   } exp_t;

   typedef struct packed {
      logic [159:0] hdr;
      logic [15:0]  eth;
      exp_t         e;
   } vec_t;

   vec_t tbl [6];

   ip_checksum_ttl #(.DATA_WIDTH(64)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .in_data                 (in_data),
      .in_wr                   (in_wr),
      .word_ETH_IP_VER         (s_w1),
      .word_IP_LEN_ID          (s_w2),
      .word_IP_CHECKSUM_SRC_HI (s_w3),
      .word_IP_DST_LO          (s_w4),
      .ip_checksum_vld         (ip_checksum_vld),
      .rd_check                (rd_check),
      .ip_checksum_is_good     (ip_checksum_is_good),
      .ip_hdr_is_ipv4          (ip_hdr_is_ipv4),
      .ip_ttl_is_good          (ip_ttl_is_good),
      .ip_new_ttl              (ip_new_ttl),
      .ip_new_checksum         (ip_new_checksum),
      .result_overflow         (result_overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (result_overflow === 1'b1) ovf_cnt++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // reference: one's-complement sum of all 10 halfwords, RFC 1624 style update
   function automatic exp_t model(input logic [159:0] hdr, input logic [15:0] eth);
      exp_t e;
      int unsigned s = 0;
      int unsigned c;
      logic [15:0] hw0, hw4, orig;
      for (int i = 0; i < 10; i++) s += hdr[159-16*i -: 16];
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
      hw0  = hdr[159:144];
      hw4  = hdr[95:80];
      orig = hdr[79:64];
      e.good     = (s == 32'hFFFF);
      e.ipv4     = (eth == 16'h0800) && (hw0[15:8] == 8'h45);
      e.ttl_good = (hw4[15:8] > 1);
      e.ttl      = (hw4[15:8] == 0) ? 8'd0 : hw4[15:8] - 8'd1;
      c = orig + 32'h100;
      if (c > 32'hFFFF) c = c - 32'h10000 + 1;
      e.ck = c[15:0];
      return e;
   endfunction

   task automatic chk_head(input exp_t e, input string tag);
      logic [15:0] eck;
`ifdef IP_CKSUM_INCR_EN
      eck = e.ck;
`else
      eck = 16'h0;
`endif
      chk({tag, "_vld"},   ip_checksum_vld, 1);
      chk({tag, "_good"},  ip_checksum_is_good, e.good);
      chk({tag, "_ipv4"},  ip_hdr_is_ipv4, e.ipv4);
      chk({tag, "_ttlok"}, ip_ttl_is_good, e.ttl_good);
      chk({tag, "_ttl"},   ip_new_ttl, e.ttl);
      chk({tag, "_ck"},    ip_new_checksum, eck);
   endtask

   // all drive tasks start and end at posedge+1
   task automatic drive(input logic [63:0] d, input logic [3:0] strb);
      in_data = d;
      in_wr   = 1'b1;
      {s_w1, s_w2, s_w3, s_w4} = strb;
      @(posedge clk); #1;
      in_wr   = 1'b0;
      {s_w1, s_w2, s_w3, s_w4} = 4'b0;
      in_data = {$urandom, $urandom};
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pop();
      rd_check = 1'b1;
      @(posedge clk); #1;
      rd_check = 1'b0;
   endtask

   task automatic send_words(input logic [159:0] h, input logic [15:0] eth, input int gap,
                             input int nwords);
      logic [31:0] filler;
      filler = $urandom;
      if (nwords > 0) drive({filler, eth, h[159:144]}, 4'b1000);
      if (nwords > 1) begin idle(gap); drive(h[143:80], 4'b0100); end
      if (nwords > 2) begin idle(gap); drive(h[79:16], 4'b0010); end
      if (nwords > 3) begin idle(gap); drive({h[15:0], filler, 16'h5a5a}, 4'b0001); end
   endtask

   task automatic send_hdr(input logic [159:0] h, input logic [15:0] eth, input int gap,
                           input bit chk_t, input bit pop_at_push, input string tag);
      send_words(h, eth, gap, 4);
      @(posedge clk); #1;
      if (chk_t) chk({tag, "_vld_n2"}, ip_checksum_vld, 0);
      if (pop_at_push) rd_check = 1'b1;
      @(posedge clk); #1;
      rd_check = 1'b0;
      if (chk_t) chk({tag, "_vld_n3"}, ip_checksum_vld, 1);
   endtask

   initial begin
      int base;
      logic [15:0]  hw [10];
      logic [159:0] h;
      logic [15:0]  eth;
      int unsigned  s;

      tbl[0] = '{160'h4500_0073_0000_4000_4011_b861_c0a8_0001_c0a8_00c7, 16'h0800, '{1, 1, 1, 8'h3F, 16'hB961}};
      tbl[1] = '{160'h4500_0073_0000_4000_4011_b862_c0a8_0001_c0a8_00c7, 16'h0800, '{0, 1, 1, 8'h3F, 16'hB962}};
      tbl[2] = '{160'h4500_0073_0000_4000_0111_f761_c0a8_0001_c0a8_00c7, 16'h0800, '{1, 1, 0, 8'h00, 16'hF861}};
      tbl[3] = '{160'h4500_0073_0000_4000_0011_f861_c0a8_0001_c0a8_00c7, 16'h0800, '{1, 1, 0, 8'h00, 16'hF961}};
      tbl[4] = '{160'h4500_0073_0000_4000_4011_b861_c0a8_0001_c0a8_00c7, 16'h86DD, '{1, 0, 1, 8'h3F, 16'hB961}};
      tbl[5] = '{160'h4600_0073_0000_4000_4011_b761_c0a8_0001_c0a8_00c7, 16'h0800, '{1, 0, 1, 8'h3F, 16'hB861}};

      reset = 1'b1; in_data = '0; in_wr = 0; rd_check = 0;
      {s_w1, s_w2, s_w3, s_w4} = 4'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_vld",  ip_checksum_vld, 0);
      chk("rst_good", ip_checksum_is_good, 0);
      chk("rst_ipv4", ip_hdr_is_ipv4, 0);
      chk("rst_ttlok", ip_ttl_is_good, 0);
      chk("rst_ttl",  ip_new_ttl, 0);
      chk("rst_ck",   ip_new_checksum, 0);
      chk("rst_ovf",  result_overflow, 0);
      reset = 1'b0;
      idle(2);

      // table vectors
      for (int i = 0; i < 6; i++) begin
         send_hdr(tbl[i].hdr, tbl[i].eth, 0, 1, 0, $sformatf("tbl%0d", i));
         chk_head(tbl[i].e, $sformatf("tbl%0d", i));
         pop();
         chk($sformatf("tbl%0d_popped", i), ip_checksum_vld, 0);
      end

      // rd_check on empty FIFO is ignored
      pop();
      chk("empty_pop_vld", ip_checksum_vld, 0);

      // 3-cycle stalls between words
      send_hdr(tbl[0].hdr, tbl[0].eth, 3, 1, 0, "stall");
      chk_head(tbl[0].e, "stall");
      pop();

      // overflow: third result dropped
      base = ovf_cnt;
      send_hdr(tbl[0].hdr, tbl[0].eth, 0, 1, 0, "ovA");
      send_hdr(tbl[1].hdr, tbl[1].eth, 0, 0, 0, "ovB");
      send_hdr(tbl[2].hdr, tbl[2].eth, 0, 0, 0, "ovC");
      idle(2);
      chk("ovf_once", ovf_cnt - base, 1);
      chk_head(tbl[0].e, "ov_head0");
      // push with simultaneous pop when full
      base = ovf_cnt;
      send_hdr(tbl[3].hdr, tbl[3].eth, 0, 0, 1, "ovD");
      idle(2);
      chk("ovf_none", ovf_cnt - base, 0);
      chk_head(tbl[1].e, "ov_head1");
      pop();
      chk_head(tbl[3].e, "ov_head3");
      pop();
      chk("ov_drained", ip_checksum_vld, 0);

      // reset mid-packet discards the partial header
      send_words(tbl[0].hdr, tbl[0].eth, 0, 2);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      drive(tbl[0].hdr[79:16], 4'b0010);
      drive({tbl[0].hdr[15:0], 48'h0}, 4'b0001);
      idle(4);
      chk("midrst_vld", ip_checksum_vld, 0);
      chk("midrst_ovf_cnt", ovf_cnt - base, 0);
      send_hdr(tbl[0].hdr, tbl[0].eth, 0, 1, 0, "postrst");
      chk_head(tbl[0].e, "postrst");
      pop();
      chk("postrst_single", ip_checksum_vld, 0);

      // random headers against the model
      for (int n = 0; n < 24; n++) begin
         for (int i = 0; i < 10; i++) hw[i] = 16'($urandom);
         if ($urandom_range(0, 1)) hw[0] = {8'h45, 8'($urandom)};
         if ($urandom_range(0, 1)) hw[4][15:8] = 8'($urandom_range(0, 3));
         eth = $urandom_range(0, 1) ? 16'h0800 : 16'($urandom);
         if ($urandom_range(0, 1)) begin
            s = 0;
            for (int i = 0; i < 10; i++) if (i != 5) s += hw[i];
            while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
            hw[5] = ~s[15:0];
         end
         for (int i = 0; i < 10; i++) h[159-16*i -: 16] = hw[i];
         send_hdr(h, eth, $urandom_range(0, 2), 1, 0, $sformatf("rnd%0d", n));
         chk_head(model(h, eth), $sformatf("rnd%0d", n));
         pop();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
